timebase_timer_bank: RTL

- Shared microsecond timebase for the FSS design.
- A prescaler divides the input clock into one-microsecond ticks and drives a free-running microsecond count.
- The same tick clocks a bank of independent down-counting timer channels, each set to one-shot or periodic mode.
- fss_top uses it for all interval timing. Each expiry is a single-cycle pulse.

---
 rtl/timebase_pkg.sv | 14 +
 rtl/timer_channel.sv | 92 +++++++++
 rtl/timebase_timer_bank.sv | 110 +++++++++++
 3 files changed

// File: rtl/timebase_pkg.sv
// Shared definitions for the microsecond timebase and its timer channels.
//   MODE_ONESHOT / MODE_PERIODIC : channel mode encodings
//   ch_state_t                   : per-channel control state
package timebase_pkg;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  typedef enum logic {
    IDLE,
    RUN
  } ch_state_t;

endpackage

// File: rtl/timer_channel.sv
// One down-counting timer channel clocked by the shared microsecond tick.
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   tick_en_i      : one-cycle microsecond tick
//   load_i         : load period_i/mode_i and start (period 0 idles the channel)
//   stop_i         : stop the channel, remaining holds for readback
//   period_i       : period in ticks
//   mode_i         : 0 = one-shot, 1 = periodic
//   remaining_o    : remaining ticks
//   running_o      : channel is in RUN
//   expire_o       : registered one-cycle expiry pulse
module timer_channel
  import timebase_pkg::*;
#(
  parameter int unsigned P_CHANNEL_WIDTH = 24
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       tick_en_i,
  input  logic                       load_i,
  input  logic                       stop_i,
  input  logic [P_CHANNEL_WIDTH-1:0] period_i,
  input  logic                       mode_i,
  output logic [P_CHANNEL_WIDTH-1:0] remaining_o,
  output logic                       running_o,
  output logic                       expire_o
);

  ch_state_t                  state_q, state_d;
  logic [P_CHANNEL_WIDTH-1:0] remaining_q, remaining_d;
  logic [P_CHANNEL_WIDTH-1:0] period_q, period_d;
  logic                       mode_q, mode_d;
  logic                       expire_q, expire_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      period_q    <= '0;
      mode_q      <= MODE_ONESHOT;
      expire_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      period_q    <= period_d;
      mode_q      <= mode_d;
      expire_q    <= expire_d;
    end
  end

  // Priority: load beats stop, stop beats tick (so a stop on the expiring tick
  // suppresses the pulse), and a load on a tick ignores that tick.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    period_d    = period_q;
    mode_d      = mode_q;
    expire_d    = 1'b0;
    if (load_i) begin
      if (period_i != '0) begin
        period_d    = period_i;
        remaining_d = period_i;
        mode_d      = mode_i;
        state_d     = RUN;
      end else begin
        remaining_d = '0;
        state_d     = IDLE;
      end
    end else if (stop_i) begin
      state_d = IDLE;
    end else if (state_q == RUN && tick_en_i) begin
      if (remaining_q == P_CHANNEL_WIDTH'(1)) begin
        expire_d = 1'b1;
        if (mode_q == MODE_PERIODIC) begin
          remaining_d = period_q;
        end else begin
          remaining_d = '0;
          state_d     = IDLE;
        end
      end else begin
        remaining_d = remaining_q - P_CHANNEL_WIDTH'(1);
      end
    end
  end

  always_comb begin
    running_o   = (state_q == RUN);
    remaining_o = remaining_q;
    expire_o    = expire_q;
  end

endmodule

// File: rtl/timebase_timer_bank.sv
// Microsecond timebase: prescaler, free-running microsecond count and a bank
// of timer channels clocked by the same tick.
// Ports:
//   I_INPUT_CLK, I_NRESET       : clock, asynchronous active-low reset
//   I_PAUSE, I_CLEAR            : freeze / synchronous clear of the timebase
//   O_MICROSEC_COUNT, O_TICK    : free-running count and registered tick pulse
//   I_CH_SEL                    : channel select for write, stop and readback
//   I_CH_WRITE, I_CH_PERIOD,
//   I_CH_MODE, I_CH_STOP        : channel control
//   O_CH_REMAINING              : remaining count of the selected channel
//   O_CH_RUNNING, O_CH_EXPIRE   : per-channel running flags and expiry pulses
module timebase_timer_bank
  import timebase_pkg::*;
#(
  parameter int unsigned P_CYCLES_PER_TICK = 50,
  parameter int unsigned P_COUNTER_WIDTH   = 32,
  parameter int unsigned P_NUM_CHANNELS    = 4,
  parameter int unsigned P_CHANNEL_WIDTH   = 24,
  localparam int unsigned CW = (P_NUM_CHANNELS > 1) ? $clog2(P_NUM_CHANNELS) : 1
) (
  input  logic                       I_INPUT_CLK,
  input  logic                       I_NRESET,
  input  logic                       I_PAUSE,
  input  logic                       I_CLEAR,
  output logic [P_COUNTER_WIDTH-1:0] O_MICROSEC_COUNT,
  output logic                       O_TICK,
  input  logic [CW-1:0]              I_CH_SEL,
  input  logic                       I_CH_WRITE,
  input  logic [P_CHANNEL_WIDTH-1:0] I_CH_PERIOD,
  input  logic                       I_CH_MODE,
  input  logic                       I_CH_STOP,
  output logic [P_CHANNEL_WIDTH-1:0] O_CH_REMAINING,
  output logic [P_NUM_CHANNELS-1:0]  O_CH_RUNNING,
  output logic [P_NUM_CHANNELS-1:0]  O_CH_EXPIRE
);

  localparam int unsigned PW = $clog2(P_CYCLES_PER_TICK);

  logic [PW-1:0]              presc_q, presc_d;
  logic [P_COUNTER_WIDTH-1:0] count_q, count_d;
  logic                       tick_q;
  logic                       tick_en;

  assign tick_en = (presc_q == PW'(P_CYCLES_PER_TICK - 1)) && !I_PAUSE && !I_CLEAR;

  always_comb begin
    presc_d = presc_q;
    count_d = count_q;
    if (I_CLEAR) begin
      presc_d = '0;
      count_d = '0;
    end else if (tick_en) begin
      presc_d = '0;
      count_d = count_q + P_COUNTER_WIDTH'(1);
    end else if (!I_PAUSE) begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_ff @(posedge I_INPUT_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      presc_q <= '0;
      count_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
      tick_q  <= tick_en;
    end
  end

  assign O_MICROSEC_COUNT = count_q;
  assign O_TICK           = tick_q;

  logic [P_NUM_CHANNELS-1:0]                      ch_load;
  logic [P_NUM_CHANNELS-1:0]                      ch_stop;
  logic [P_NUM_CHANNELS-1:0][P_CHANNEL_WIDTH-1:0] ch_rem;

  // Out-of-range selects match no channel, so writes/stops drop and readback is 0.
  always_comb begin
    ch_load        = '0;
    ch_stop        = '0;
    O_CH_REMAINING = '0;
    for (int i = 0; i < int'(P_NUM_CHANNELS); i++) begin
      if (I_CH_SEL == CW'(i)) begin
        ch_load[i]     = I_CH_WRITE;
        ch_stop[i]     = I_CH_STOP;
        O_CH_REMAINING = ch_rem[i];
      end
    end
  end

  for (genvar g = 0; g < int'(P_NUM_CHANNELS); g++) begin : g_ch
    timer_channel #(
      .P_CHANNEL_WIDTH(P_CHANNEL_WIDTH)
    ) u_ch (
      .clk_i      (I_INPUT_CLK),
      .rst_ni     (I_NRESET),
      .tick_en_i  (tick_en),
      .load_i     (ch_load[g]),
      .stop_i     (ch_stop[g]),
      .period_i   (I_CH_PERIOD),
      .mode_i     (I_CH_MODE),
      .remaining_o(ch_rem[g]),
      .running_o  (O_CH_RUNNING[g]),
      .expire_o   (O_CH_EXPIRE[g])
    );
  end

endmodule
